// File: rtl/banked_lsu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : banked_lsu_ctrl_if
// Purpose  : Request/response handshake and per-bank bus bundle for
//            banked_lsu_ctrl. The slave modport is the controller's view and
//            the master modport is the requester/memory side.
// Revision : 1.0 - initial release
// ============================================================================
interface banked_lsu_ctrl_if #(
  parameter int NUM_BANKS = 4,
  parameter int BANK_AW   = 10
);
  logic                         i_req_valid;
  logic                         o_req_ready;
  logic [31:0]                  i_addr;
  logic [31:0]                  i_wdata;
  logic                         i_wren;
  logic [1:0]                   i_size;
  logic                         i_unsigned;
  logic [NUM_BANKS*BANK_AW-1:0] o_bank_addr;
  logic [NUM_BANKS*8-1:0]       o_bank_wdata;
  logic [NUM_BANKS-1:0]         o_bank_we;
  logic [NUM_BANKS-1:0]         o_bank_re;
  logic [NUM_BANKS*8-1:0]       i_bank_rdata;
  logic                         o_rsp_valid;
  logic [31:0]                  o_rdata;
  logic                         o_err;

  modport slave (
    input  i_req_valid, i_addr, i_wdata, i_wren, i_size, i_unsigned, i_bank_rdata,
    output o_req_ready, o_bank_addr, o_bank_wdata, o_bank_we, o_bank_re,
           o_rsp_valid, o_rdata, o_err
  );

  modport master (
    output i_req_valid, i_addr, i_wdata, i_wren, i_size, i_unsigned, i_bank_rdata,
    input  o_req_ready, o_bank_addr, o_bank_wdata, o_bank_we, o_bank_re,
           o_rsp_valid, o_rdata, o_err
  );
endinterface
`default_nettype wire

// File: rtl/banked_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : banked_lsu_ctrl
// Purpose  : Load/store controller over NUM_BANKS byte-wide banks with
//            low-order byte interleaving. One access in flight at a time:
//            stores respond one cycle after acceptance, loads three cycles.
// Options  : define LSU_MISALIGN_TRAP_EN to reject misaligned half/word
//            accesses with o_err instead of splitting them across banks.
// Revision : 1.0 - initial release
// ============================================================================
module banked_lsu_ctrl #(
  parameter int NUM_BANKS = 4,
  parameter int BANK_AW   = 10
) (
  input  wire logic          i_clk,
  input  wire logic          i_reset,
  banked_lsu_ctrl_if.slave   bus
);
  // Bank-select width and the number of address bits that matter at all.
  localparam int c_SEL_W = $clog2(NUM_BANKS);
  localparam int c_AW    = c_SEL_W + BANK_AW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RDATA = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [c_AW-1:0]             r_addr;
  logic [31:0]                 r_wdata;
  logic                        r_wren;
  logic [1:0]                  r_size;
  logic                        r_unsigned;
  logic [31:0]                 r_rdata;

  logic                        w_accept;
  logic                        w_ready;
  logic                        w_rsp_valid;
  logic                        w_err;
  logic                        w_drive;
  logic                        w_bad;
  logic [2:0]                  w_nbytes;
  logic [c_SEL_W-1:0]          w_k;
  logic                        w_carry;
  logic [c_SEL_W-1:0]          w_idx;
  logic [31:0]                 w_raw;
  logic [31:0]                 w_ext;
  logic [NUM_BANKS*BANK_AW-1:0] w_bank_addr;
  logic [NUM_BANKS*8-1:0]      w_bank_wdata;
  logic [NUM_BANKS-1:0]        w_bank_we;
  logic [NUM_BANKS-1:0]        w_bank_re;
  logic                        w_unused_addr;

  // Address bits above the bank+row field wrap away by design.
  assign w_unused_addr = ^bus.i_addr[31:c_AW];
  assign w_accept      = bus.i_req_valid && (r_state == S_IDLE);

  // State register; reset aborts any access in flight.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Capture the request on the accepting handshake only.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wren     <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
    end else if (w_accept) begin
      r_addr     <= bus.i_addr[c_AW-1:0];
      r_wdata    <= bus.i_wdata;
      r_wren     <= bus.i_wren;
      r_size     <= bus.i_size;
      r_unsigned <= bus.i_unsigned;
    end
  end

  // Load result register; holds between load responses.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)                r_rdata <= '0;
    else if (r_state == S_RDATA) r_rdata <= w_ext;
  end

  // Access length and error classification of the registered request.
  always_comb begin
    w_nbytes = 3'd0;
    w_bad    = 1'b0;
    case (r_size)
      2'b00:   w_nbytes = 3'd1;
      2'b01:   w_nbytes = 3'd2;
      2'b10:   w_nbytes = 3'd4;
      default: w_bad    = 1'b1;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    if ((r_size == 2'b01) && r_addr[0])            w_bad = 1'b1;
    if ((r_size == 2'b10) && (r_addr[1:0] != 2'b00)) w_bad = 1'b1;
`else
    w_bad = w_bad;
`endif
  end

  // Next-state and handshake/response outputs.
  always_comb begin
    w_next      = r_state;
    w_ready     = 1'b0;
    w_rsp_valid = 1'b0;
    w_err       = 1'b0;
    w_drive     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.i_req_valid) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_bad) begin
          w_rsp_valid = 1'b1;
          w_err       = 1'b1;
          w_next      = S_IDLE;
        end else if (r_wren) begin
          w_drive     = 1'b1;
          w_rsp_valid = 1'b1;
          w_next      = S_IDLE;
        end else begin
          w_drive     = 1'b1;
          w_next      = S_RDATA;
        end
      end
      S_RDATA: w_next = S_RESP;
      S_RESP: begin
        w_rsp_valid = 1'b1;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Per-bank drive: bank b holds access byte k = (b - addr) mod NUM_BANKS,
  // and its row steps by one when the byte index wrapped past the last bank.
  always_comb begin
    w_bank_addr  = '0;
    w_bank_wdata = '0;
    w_bank_we    = '0;
    w_bank_re    = '0;
    w_k          = '0;
    w_carry      = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_k     = c_SEL_W'(b) - r_addr[c_SEL_W-1:0];
      w_carry = (c_SEL_W'(b) < r_addr[c_SEL_W-1:0]);
      if (w_drive && (32'(w_k) < 32'(w_nbytes))) begin
        w_bank_addr[b*BANK_AW +: BANK_AW] = r_addr[c_AW-1:c_SEL_W] + BANK_AW'(w_carry);
        if (r_wren) begin
          w_bank_we[b]          = 1'b1;
          w_bank_wdata[b*8 +: 8] = r_wdata[{w_k[1:0], 3'b000} +: 8];
        end else begin
          w_bank_re[b] = 1'b1;
        end
      end
    end
  end

  // Gather returned bytes in access order, then sign/zero extend.
  always_comb begin
    w_raw = '0;
    w_idx = '0;
    for (int k = 0; k < 4; k++) begin
      w_idx              = r_addr[c_SEL_W-1:0] + c_SEL_W'(k);
      w_raw[k*8 +: 8]    = bus.i_bank_rdata[{w_idx, 3'b000} +: 8];
    end
    case (r_size)
      2'b00:   w_ext = r_unsigned ? {24'd0, w_raw[7:0]}  : {{24{w_raw[7]}},  w_raw[7:0]};
      2'b01:   w_ext = r_unsigned ? {16'd0, w_raw[15:0]} : {{16{w_raw[15]}}, w_raw[15:0]};
      2'b10:   w_ext = w_raw;
      default: w_ext = '0;
    endcase
  end

  assign bus.o_req_ready  = w_ready;
  assign bus.o_rsp_valid  = w_rsp_valid;
  assign bus.o_err        = w_err;
  assign bus.o_rdata      = r_rdata;
  assign bus.o_bank_addr  = w_bank_addr;
  assign bus.o_bank_wdata = w_bank_wdata;
  assign bus.o_bank_we    = w_bank_we;
  assign bus.o_bank_re    = w_bank_re;

endmodule
`default_nettype wire

// File: tb/tb_banked_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_banked_lsu_ctrl
// Purpose  : Self-checking bench for banked_lsu_ctrl (4 banks, 10-bit rows):
//            directed vector table, reset/throughput sequences and a random
//            phase scored against a flat byte-addressed reference memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_banked_lsu_ctrl;
  localparam int NB    = 4;
  localparam int AW    = 10;
  localparam int MEMSZ = NB * (1 << AW);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  banked_lsu_ctrl_if #(.NUM_BANKS(NB), .BANK_AW(AW)) bus ();
  banked_lsu_ctrl #(.NUM_BANKS(NB), .BANK_AW(AW)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  // Physical bank storage (slot = row*NB + bank) and the reference memory.
  logic [7:0]      bank_store [MEMSZ];
  logic [7:0]      ref_mem    [MEMSZ];
  logic [NB*8-1:0] rdata_q = '0;
  assign bus.i_bank_rdata = rdata_q;

  // Synchronous bank model: write on we, return read byte next cycle.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      int slot;
      slot = int'(bus.o_bank_addr[b*AW +: AW]) * NB + b;
      if (bus.o_bank_we[b]) bank_store[slot] = bus.o_bank_wdata[b*8 +: 8];
      if (bus.o_bank_re[b]) rdata_q[b*8 +: 8] <= bank_store[slot];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] last_rdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int nbytes_of(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
  endfunction

  function automatic logic is_err(input logic [1:0] sz, input logic [31:0] a);
    logic e;
    e = (sz == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    if (sz == 2'b01 && a[0] != 1'b0)    e = 1'b1;
    if (sz == 2'b10 && a[1:0] != 2'b00) e = 1'b1;
`else
    e = e | (a[0] & 1'b0);
`endif
    return e;
  endfunction

  function automatic int flat(input logic [31:0] a, input int k);
    return int'((a + 32'(k)) & 32'(MEMSZ - 1));
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    for (int k = 0; k < nbytes_of(sz); k++) ref_mem[flat(a, k)] = d[k*8 +: 8];
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < nbytes_of(sz); k++) v[k*8 +: 8] = ref_mem[flat(a, k)];
    if (sz == 2'b00 && !u) v = {{24{v[7]}}, v[7:0]};
    if (sz == 2'b01 && !u) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  // Present one request for exactly one accepting edge; returns #1 into ISSUE.
  task automatic send(input logic wren, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic u);
    @(negedge clk);
    bus.i_wren = wren; bus.i_addr = a; bus.i_wdata = d;
    bus.i_size = sz;   bus.i_unsigned = u; bus.i_req_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_req_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  typedef struct {
    string       name;
    logic        wren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [3:0]  we;
    logic [3:0]  re;
    logic [39:0] baddr;
    logic [31:0] bwdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt [11];

  initial begin
    bus.i_req_valid = 1'b0; bus.i_addr = '0; bus.i_wdata = '0;
    bus.i_wren = 1'b0; bus.i_size = 2'b00; bus.i_unsigned = 1'b0;
    for (int i = 0; i < MEMSZ; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      bank_store[i] = v;
      ref_mem[i]    = v;
    end
    // Preloads: flat byte address a lives in bank a%4, row a/4.
    bank_store[3] = 8'h80; ref_mem[3] = 8'h80;
    bank_store[4] = 8'hFF; ref_mem[4] = 8'hFF;
    bank_store[13] = 8'h9C; ref_mem[13] = 8'h9C;
    bank_store[2] = 8'hF0; ref_mem[2] = 8'hF0;

    //          name     wr   addr           wdata          sz     u   we       re       baddr {b3,b2,b1,b0}                  bwdata         err   rdata
    vt[0]  = '{"sw006",  1, 32'h0000_0006, 32'hAABBCCDD, 2'b10, 0, 4'b1111, 4'b0000, {10'd1,10'd1,10'd2,10'd2},       32'hCCDDAABB, 1'b0, 32'h0};
    vt[1]  = '{"lw006",  0, 32'h0000_0006, 32'h0,        2'b10, 0, 4'b0000, 4'b1111, {10'd1,10'd1,10'd2,10'd2},       32'h0,        1'b0, 32'hAABBCCDD};
    vt[2]  = '{"lh003",  0, 32'h0000_0003, 32'h0,        2'b01, 0, 4'b0000, 4'b1001, {10'd0,10'd0,10'd0,10'd1},       32'h0,        1'b0, 32'hFFFFFF80};
    vt[3]  = '{"lbu00D", 0, 32'h0000_000D, 32'h0,        2'b00, 1, 4'b0000, 4'b0010, {10'd0,10'd0,10'd3,10'd0},       32'h0,        1'b0, 32'h0000009C};
    vt[4]  = '{"swFFE",  1, 32'h0000_0FFE, 32'h11223344, 2'b10, 0, 4'b1111, 4'b0000, {10'd1023,10'd1023,10'd0,10'd0}, 32'h33441122, 1'b0, 32'h0};
    vt[5]  = '{"lhuFFF", 0, 32'h0000_0FFF, 32'h0,        2'b01, 1, 4'b0000, 4'b1001, {10'd1023,10'd0,10'd0,10'd0},    32'h0,        1'b0, 32'h00002233};
    vt[6]  = '{"sz11st", 1, 32'h0000_0040, 32'h12345678, 2'b11, 0, 4'b0000, 4'b0000, 40'd0,                           32'h0,        1'b1, 32'h0};
    vt[7]  = '{"sz11ld", 0, 32'h0000_0040, 32'h0,        2'b11, 1, 4'b0000, 4'b0000, 40'd0,                           32'h0,        1'b1, 32'h0};
    vt[8]  = '{"sh001",  1, 32'h0000_0001, 32'h00001234, 2'b01, 0, 4'b0110, 4'b0000, 40'd0,                           32'h00123400, 1'b0, 32'h0};
`ifdef LSU_MISALIGN_TRAP_EN
    vt[9]  = '{"lb002",  0, 32'h0000_0002, 32'h0,        2'b00, 0, 4'b0000, 4'b0100, 40'd0,                           32'h0,        1'b0, 32'hFFFFFFF0};
`else
    vt[9]  = '{"lb002",  0, 32'h0000_0002, 32'h0,        2'b00, 0, 4'b0000, 4'b0100, 40'd0,                           32'h0,        1'b0, 32'h00000012};
`endif
    vt[10] = '{"lwhigh", 0, 32'hABCD_0006, 32'h0,        2'b10, 0, 4'b0000, 4'b1111, {10'd1,10'd1,10'd2,10'd2},       32'h0,        1'b0, 32'hAABBCCDD};
    // Requests that trap become error responses with no bank activity.
    for (int i = 0; i < 11; i++) begin
      if (is_err(vt[i].size, vt[i].addr)) begin
        vt[i].we = '0; vt[i].re = '0; vt[i].baddr = '0; vt[i].bwdata = '0; vt[i].err = 1'b1;
      end
    end

    // Reset state.
    #12;
    check("rst_ready", bus.o_req_ready, 1);
    check("rst_rsp",   bus.o_rsp_valid, 0);
    check("rst_err",   bus.o_err, 0);
    check("rst_rdata", bus.o_rdata, 0);
    check("rst_bank",  {bus.o_bank_we, bus.o_bank_re, bus.o_bank_wdata}, 0);
    check("rst_baddr", bus.o_bank_addr, 0);
    @(negedge clk); rst_n = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 11; i++) begin
      send(vt[i].wren, vt[i].addr, vt[i].wdata, vt[i].size, vt[i].uns);
      check({vt[i].name, "_ready"}, bus.o_req_ready, 0);
      check({vt[i].name, "_we"},    bus.o_bank_we, vt[i].we);
      check({vt[i].name, "_re"},    bus.o_bank_re, vt[i].re);
      check({vt[i].name, "_baddr"}, bus.o_bank_addr, vt[i].baddr);
      check({vt[i].name, "_bwd"},   bus.o_bank_wdata, vt[i].bwdata);
      check({vt[i].name, "_rsp1"},  bus.o_rsp_valid, vt[i].wren | vt[i].err);
      check({vt[i].name, "_err"},   bus.o_err, vt[i].err);
      if (!vt[i].wren && !vt[i].err) begin
        step();
        check({vt[i].name, "_rsp2"}, {bus.o_rsp_valid, bus.o_bank_re}, 0);
        step();
        check({vt[i].name, "_rsp3"}, {bus.o_rsp_valid, bus.o_err}, 2'b10);
        check({vt[i].name, "_rdata"}, bus.o_rdata, vt[i].rdata);
        last_rdata = vt[i].rdata;
      end
      if (vt[i].wren && !vt[i].err) ref_store(vt[i].addr, vt[i].wdata, vt[i].size);
      step();
      check({vt[i].name, "_idle"}, {bus.o_req_ready, bus.o_rsp_valid}, 2'b10);
      check({vt[i].name, "_hold"}, bus.o_rdata, last_rdata);
    end

    // Valid held high: the request seen during ISSUE is dropped, not queued.
    @(negedge clk);
    bus.i_wren = 1'b1; bus.i_addr = 32'h100; bus.i_wdata = 32'h0102_0304;
    bus.i_size = 2'b10; bus.i_unsigned = 1'b0; bus.i_req_valid = 1'b1;
    step();
    check("b2b_issue1", {bus.o_req_ready, bus.o_rsp_valid, bus.o_bank_we}, {2'b01, 4'hF});
    bus.i_wdata = 32'hDEAD_BEEF;
    step();
    check("b2b_ignored", {bus.o_req_ready, bus.o_rsp_valid, bus.o_bank_we}, {2'b10, 4'h0});
    bus.i_addr = 32'h104; bus.i_wdata = 32'h5566_7788;
    step();
    bus.i_req_valid = 1'b0;
    check("b2b_issue2", {bus.o_bank_we, bus.o_bank_wdata}, {4'hF, 32'h5566_7788});
    ref_store(32'h100, 32'h0102_0304, 2'b10);
    ref_store(32'h104, 32'h5566_7788, 2'b10);
    step();
    send(1'b0, 32'h100, 32'h0, 2'b10, 1'b0);
    step(); step();
    check("b2b_readback", bus.o_rdata, 32'h0102_0304);
    last_rdata = 32'h0102_0304;
    step();

    // Reset during RDATA: immediate return to idle, no response afterwards.
    send(1'b0, 32'h104, 32'h0, 2'b10, 1'b0);
    step();
    #1 rst_n = 1'b0;
    #1;
    check("rstld_out", {bus.o_req_ready, bus.o_rsp_valid, bus.o_err, bus.o_bank_we, bus.o_bank_re}, {3'b100, 8'h00});
    check("rstld_rdata", bus.o_rdata, 0);
    check("rstld_bank", {bus.o_bank_addr, bus.o_bank_wdata}, 0);
    last_rdata = '0;
    @(negedge clk); rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
        step();
        if (bus.o_rsp_valid) seen++;
      end
      check("rstld_norsp", seen, 0);
    end

    // Reset during a store's ISSUE: the write is withdrawn before the edge.
    send(1'b1, 32'h200, 32'hCAFE_F00D, 2'b10, 1'b0);
    check("rstst_we", bus.o_bank_we, 4'hF);
    #1 rst_n = 1'b0;
    #1;
    check("rstst_abort", {bus.o_bank_we, bus.o_rsp_valid}, 0);
    @(negedge clk); rst_n = 1'b1;
    send(1'b0, 32'h200, 32'h0, 2'b10, 1'b0);
    step(); step();
    check("rstst_mem", bus.o_rdata, ref_load(32'h200, 2'b10, 1'b0));
    last_rdata = ref_load(32'h200, 2'b10, 1'b0);
    step();

    // Random traffic against the reference memory.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, d;
      logic [1:0]  sz;
      logic        wr, u, e;
      int          r, nb;
      a  = $urandom;
      r  = $urandom_range(0, 3);
      if (r == 0)      a[11:0] = 12'hFFC + 12'($urandom_range(0, 3));
      else if (r == 1) a[11:0] = 12'($urandom_range(0, 63));
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      wr = 1'($urandom);
      u  = 1'($urandom);
      d  = $urandom;
      e  = is_err(sz, a);
      nb = e ? 0 : nbytes_of(sz);
      send(wr, a, d, sz, u);
      check("rnd_issue", {bus.o_rsp_valid, bus.o_err}, {wr | e, e});
      check("rnd_we", $countones(bus.o_bank_we), wr ? nb : 0);
      check("rnd_re", $countones(bus.o_bank_re), wr ? 0 : nb);
      if (wr && !e) ref_store(a, d, sz);
      if (!wr && !e) begin
        step();
        step();
        check("rnd_rsp", {bus.o_rsp_valid, bus.o_err}, 2'b10);
        check("rnd_rdata", bus.o_rdata, ref_load(a, sz, u));
        last_rdata = ref_load(a, sz, u);
      end
      step();
      check("rnd_idle", {bus.o_req_ready, bus.o_rsp_valid, bus.o_rdata}, {2'b10, last_rdata});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
